// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divider controller
//
// Contents:
//   state_t     FSM state encoding (IDLE, RUN)
//   MIN_RATIO   smallest divide ratio that produces a valid waveform
//   ratio_bits  counter width needed to hold a given maximum ratio
package div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_RATIO = 2;

  function automatic int ratio_bits(input int max_ratio);
    return $clog2(max_ratio + 1);
  endfunction

endpackage

// File: rtl/div_period_cnt.sv
// rtl/div_period_cnt.sv - period counter with registered div_out/tick
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        start a new period on this edge (counter=0, tick=1, div_out=1)
//   run         advance the counter within the current period
//   ratio       active divide ratio N (>= 2)
//   last        counter is at N-1 (period boundary)
//   tick        one-cycle strobe on the first cycle of each period
//   div_out     high for counts 0..ceil(N/2)-1, low for the rest
// With neither load nor run the counter parks at 0 with both outputs low.
module div_period_cnt
  import div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] ratio,
  output logic             last,
  output logic             tick,
  output logic             div_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half;

  // ceil(N/2) computed without a carry bit so N = 2^CNT_W-1 still fits
  assign half    = (ratio >> 1) + {{(CNT_W-1){1'b0}}, ratio[0]};
  // cnt never exceeds N-2 when run is asserted, so the increment cannot wrap
  assign cnt_inc = cnt + 1'b1;
  assign last    = (cnt == ratio - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tick    <= 1'b0;
      div_out <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      tick    <= 1'b1;
      div_out <= 1'b1;
    end else if (run) begin
      cnt     <= cnt_inc;
      tick    <= 1'b0;
      div_out <= (cnt_inc < half);
    end else begin
      cnt     <= '0;
      tick    <= 1'b0;
      div_out <= 1'b0;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - programmable frequency divider with deferred ratio changes
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          run enable, honoured only at period boundaries
//   req_valid   ratio-change request valid
//   req_ratio   requested divide ratio
//   req_ready   request accepted on req_valid & req_ready (no pending ratio)
//   req_err     pulse: accepted ratio below MIN_RATIO was discarded
//   applied     pulse: a new ratio became active
//   cur_ratio   active divide ratio
//   busy        FSM is in RUN
//   tick        strobe on the first cycle of each output period
//   div_out     divided square wave
module div_ctrl
  import div_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_ratio,
  output logic             req_ready,
  output logic             req_err,
  output logic             applied,
  output logic [CNT_W-1:0] cur_ratio,
  output logic             busy,
  output logic             tick,
  output logic             div_out
);

  localparam logic [CNT_W-1:0] MIN_R = CNT_W'(MIN_RATIO);
  localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_RATIO);

  state_t           state, state_n;
  logic             load, run, last;
  logic             pend_valid;
  logic [CNT_W-1:0] pend_ratio;
  logic             accept, ratio_ok, at_bnd;

  assign req_ready = !pend_valid;
  assign busy      = (state == RUN);
  assign accept    = req_valid && req_ready;
  assign ratio_ok  = (req_ratio >= MIN_R);
  assign at_bnd    = (state == RUN) && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    run     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!last)   run     = 1'b1;
        else if (en) load    = 1'b1;
        else         state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Ratio changes land only in IDLE or on a boundary edge, so the period
  // counter always sees a ratio that is stable for a whole period. A pending
  // ratio is drained at every boundary, including the one that drops to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ratio  <= DEF_R;
      pend_ratio <= '0;
      pend_valid <= 1'b0;
      req_err    <= 1'b0;
      applied    <= 1'b0;
    end else begin
      req_err <= accept && !ratio_ok;
      applied <= 1'b0;
      if (accept && ratio_ok && (state == IDLE || at_bnd)) begin
        // pend_valid is necessarily clear here because req_ready was high
        cur_ratio <= req_ratio;
        applied   <= 1'b1;
      end else if (at_bnd && pend_valid) begin
        cur_ratio  <= pend_ratio;
        pend_valid <= 1'b0;
        applied    <= 1'b1;
      end else if (accept && ratio_ok) begin
        pend_ratio <= req_ratio;
        pend_valid <= 1'b1;
      end
    end
  end

  div_period_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .run     (run),
    .ratio   (cur_ratio),
    .last    (last),
    .tick    (tick),
    .div_out (div_out)
  );

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl
module tb_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       req_valid;
  logic [7:0] req_ratio;
  logic       req_ready;
  logic       req_err;
  logic       applied;
  logic [7:0] cur_ratio;
  logic       busy;
  logic       tick;
  logic       div_out;

  int npass  = 0;
  int ntotal = 0;
  int n;
  int acc_tick;
  int acc_rdy;

  div_ctrl #(
    .CNT_W     (8),
    .DEF_RATIO (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ratio (req_ratio),
    .req_ready (req_ready),
    .req_err   (req_err),
    .applied   (applied),
    .cur_ratio (cur_ratio),
    .busy      (busy),
    .tick      (tick),
    .div_out   (div_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal = ntotal + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until tick is seen, bounded so a dead divider cannot hang the run.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt = cnt + 1;
    end while (!tick && cnt < 64);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    req_valid = 1'b0;
    req_ratio = 8'd0;
    step();
    step();
    chk("rst_div", div_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_err", req_err, 0);
    chk("rst_applied", applied, 0);
    chk("rst_ratio", cur_ratio, 2);

    // divide-by-2: div_out and tick alternate starting one cycle after en
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("n2_div", div_out, (i % 2 == 0));
      chk("n2_tick", tick, (i % 2 == 0));
    end
    chk("n2_busy", busy, 1);

    // ratio 3 requested mid-period; takes effect at the next boundary
    step();
    req_valid = 1'b1;
    req_ratio = 8'd3;
    step();
    req_valid = 1'b0;
    chk("n3_ready_low", req_ready, 0);
    chk("n3_ratio_old", cur_ratio, 2);
    chk("n3_applied_early", applied, 0);
    for (int j = 0; j < 6; j++) begin
      step();
      chk("n3_div", div_out, (j % 3 != 2));
      chk("n3_tick", tick, (j % 3 == 0));
      chk("n3_applied", applied, (j == 0));
    end
    chk("n3_ratio", cur_ratio, 3);
    chk("n3_ready_back", req_ready, 1);

    // illegal ratios 1 and 0, the first one offered in a boundary cycle
    req_valid = 1'b1;
    req_ratio = 8'd1;
    step();
    chk("err1_pulse", req_err, 1);
    chk("err1_tick", tick, 1);
    chk("err1_applied", applied, 0);
    req_ratio = 8'd0;
    step();
    chk("err0_pulse", req_err, 1);
    chk("err0_div", div_out, 1);
    chk("err0_ratio", cur_ratio, 3);
    req_valid = 1'b0;
    step();
    chk("err_clear", req_err, 0);
    chk("err_div_low", div_out, 0);
    chk("err_ready", req_ready, 1);
    step();
    chk("err_tick", tick, 1);

    // move to ratio 8
    req_valid = 1'b1;
    req_ratio = 8'd8;
    step();
    req_valid = 1'b0;
    chk("n8_ready_low", req_ready, 0);
    step();
    step();
    chk("n8_tick", tick, 1);
    chk("n8_applied", applied, 1);
    chk("n8_ratio", cur_ratio, 8);

    // back-to-back 5 then 7: 7 waits until the 5 has been applied
    req_valid = 1'b1;
    req_ratio = 8'd5;
    step();
    chk("b2b_ready_low", req_ready, 0);
    req_ratio = 8'd7;
    acc_tick = 0;
    acc_rdy  = 0;
    for (int t = 2; t < 8; t++) begin
      step();
      acc_tick = acc_tick + int'(tick);
      acc_rdy  = acc_rdy + int'(req_ready);
    end
    chk("b2b_no_tick_in_8", acc_tick, 0);
    chk("b2b_held_off", acc_rdy, 0);
    step();
    chk("b2b_tick8", tick, 1);
    chk("b2b_ratio5", cur_ratio, 5);
    chk("b2b_applied5", applied, 1);
    chk("b2b_ready_up", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("b2b_7_pending", req_ready, 0);
    chk("b2b_ratio_still5", cur_ratio, 5);
    wait_tick(n);
    chk("b2b_period5", n + 1, 5);
    chk("b2b_ratio7", cur_ratio, 7);
    chk("b2b_applied7", applied, 1);
    wait_tick(n);
    chk("b2b_period7", n, 7);

    // ratio 6, then drop en one cycle into a period
    req_valid = 1'b1;
    req_ratio = 8'd6;
    step();
    req_valid = 1'b0;
    wait_tick(n);
    chk("n6_period7", n + 1, 7);
    chk("n6_ratio", cur_ratio, 6);
    step();
    en = 1'b0;
    for (int p = 2; p < 6; p++) begin
      step();
      chk("drop_div", div_out, (p < 3));
      chk("drop_busy", busy, 1);
    end
    step();
    chk("idle_busy", busy, 0);
    chk("idle_div", div_out, 0);
    chk("idle_tick", tick, 0);
    step();
    chk("idle_stay", busy, 0);

    // accept in IDLE applies on the accepting edge
    req_valid = 1'b1;
    req_ratio = 8'd4;
    step();
    req_valid = 1'b0;
    chk("idle_acc_ratio", cur_ratio, 4);
    chk("idle_acc_applied", applied, 1);
    chk("idle_acc_ready", req_ready, 1);
    step();
    chk("idle_acc_pulse_end", applied, 0);
    en = 1'b1;
    step();
    chk("reraise_tick", tick, 1);
    chk("reraise_div", div_out, 1);
    chk("reraise_busy", busy, 1);

    // asynchronous reset mid-period at N=4 with a ratio pending
    req_valid = 1'b1;
    req_ratio = 8'd9;
    step();
    req_valid = 1'b0;
    chk("pre_rst_pending", req_ready, 0);
    chk("pre_rst_div", div_out, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_div", div_out, 0);
    chk("arst_tick", tick, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_ratio", cur_ratio, 2);
    chk("arst_applied", applied, 0);
    step();
    chk("arst_hold", busy, 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
